fir_l3_stream_ctrl: RTL and testbench
=====================================

Name: fir_l3_stream_ctrl

Overview:
Stream controller for the L=3 reduced-complexity parallel FIR core.
- Input side: collects a serial 16-bit sample stream into 3-lane blocks and issues each block to the core with a one-cycle advance strobe. The core's state moves only on that strobe.
- Output side: tracks the core's pipeline latency, captures valid 3-lane result blocks into a block FIFO, and serializes them onto a 64-bit valid/ready output stream.
- Supports flush: zero-pads a partial block and drains the core pipeline.

Parameters:
DATA_IN_WIDTH, 16, input sample and lane width
DATA_OUT_WIDTH, 64, result lane and output width
FIR_LATENCY, 2, advances between issuing a block and its result appearing on blk_res_*; legal range 1..8
FIFO_DEPTH, 4, result FIFO depth in 3-lane blocks; power of two, minimum 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_data  in  DATA_IN_WIDTH  input sample, signed
s_valid  in  1  input sample valid
s_ready  out  1  controller accepts a sample
flush  in  1  level request: pad, issue, and drain
flush_busy  out  1  flush in progress
blk_data_1/2/3  out  DATA_IN_WIDTH each  lanes to core inputs data_in_1..3
blk_adv  out  1  core advance strobe, one cycle per block
blk_res_1/2/3  in  DATA_OUT_WIDTH each  core outputs data_out_1..3
m_data  out  DATA_OUT_WIDTH  serialized result
m_lane  out  2  lane index of m_data: 0, 1 or 2
m_valid  out  1  output valid
m_ready  in  1  downstream ready

Behaviour:
- Reset values:
  - State FILL; lane_cnt 0.
  - All lane registers, blk_data_* and the tag shift register are 0; the FIFO is empty.
  - blk_adv, m_valid, m_data, m_lane and flush_busy are 0.
- s_ready:
  - Equals (state==FILL && !flush && !reset); it is combinational.
  - A sample is accepted when s_valid && s_ready. It is written to lane[lane_cnt] and lane_cnt increments.
  - An accept with lane_cnt==2 moves the state to ISSUE and returns lane_cnt to 0.
- FILL with flush==1: enter PAD.
  - Lanes at index >= lane_cnt are zeroed; then go to ISSUE with pad_flag=1.
  - If lane_cnt==0, skip the padded block and go directly to DRAIN.
- ISSUE:
  - blk_data_* are registered and stable for the whole ISSUE state.
  - blk_adv=1 in a cycle when fifo_full==0, a same-cycle pop makes room, or tag[FIR_LATENCY-1]==0.
  - After the advance: go to FILL, or to DRAIN with drain_cnt=FIR_LATENCY when pad_flag or flush was the cause.
- Tag shift register (FIR_LATENCY bits):
  - On each blk_adv, shift in 1 for a data block or padded block, and 0 for a drain block.
  - In the blk_adv cycle, if the pre-shift tag[FIR_LATENCY-1]==1, push {blk_res_1, blk_res_2, blk_res_3} into the FIFO.
  - A push never occurs while the FIFO is full; the issue gating above guarantees this.
- DRAIN:
  - blk_data_*=0. Issue one zero block per advance under the same gating, decrementing drain_cnt.
  - At drain_cnt==0, return to FILL and clear flush_busy.
- flush_busy:
  - Asserts the cycle after flush is first seen in FILL.
  - Stays high until drain completes.
  - flush held high after completion starts another flush; this is legal, and re-drains zero blocks only.
- Output serializer:
  - m_valid = FIFO non-empty; m_data = head lane selected by an internal sel register (0..2); m_lane = sel.
  - On m_valid && m_ready: sel increments. At sel==2, pop the FIFO and reset sel to 0.
  - Lane order is always 1, 2, 3; sel never advances without a handshake.
- Simultaneous pop and push on the same cycle are allowed when the FIFO is full; the count is unchanged.
- No sample is lost or duplicated. Output count equals 3 × (real blocks + padded blocks).
- Reset asserted mid-operation: all state returns to reset values on the next edge, and in-flight blocks are discarded. The core must receive the same reset.
- Arithmetic: none on data. Result widths pass through unchanged.

Test Plan:
Mock core for all tests: blk_res_i = sign-extended blk_data_i delayed by FIR_LATENCY advances. Defaults apply unless stated.
- Stream 1..12 with m_ready=1, then pulse flush → m_data 1..12 in order with m_lane 0,1,2 repeating. Exactly 12 beats; flush_busy falls after 2 drain advances.
- Send 5, 6, then flush → outputs 5, 6, 0 on lanes 0, 1, 2. Exactly 3 beats.
- Hold m_ready=0 and stream samples → blk_adv stops once the FIFO holds 4 blocks, and s_ready stays low afterward. Release m_ready with random backpressure → all samples out in order.
- Random s_valid gaps (~30% idle) over 300 samples plus a final flush → the scoreboard matches; blk_adv never exceeds one per 3 accepts outside drain.
- Assert reset for 1 cycle mid-stream with 2 blocks in flight → next cycle m_valid=0, s_ready=1, and flush_busy=0. A fresh stream of 7..12 plus flush outputs only 7..12.
- FIR_LATENCY=1 and FIFO_DEPTH=2 with negative samples (-1, -32768) → sign-extended 64-bit outputs are correct, and drain uses exactly 1 advance.

Source files
------------

// File: rtl/fir_l3_stream_ctrl.sv
// Stream controller for the L=3 parallel FIR core: packs serial samples into
// 3-lane blocks, tracks core latency with a tag shift register, and serializes results.
module fir_l3_stream_ctrl #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 64,
  parameter int FIR_LATENCY    = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_IN_WIDTH-1:0]  s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      flush,
  output logic                      flush_busy,
  output logic [DATA_IN_WIDTH-1:0]  blk_data_1,
  output logic [DATA_IN_WIDTH-1:0]  blk_data_2,
  output logic [DATA_IN_WIDTH-1:0]  blk_data_3,
  output logic                      blk_adv,
  input  logic [DATA_OUT_WIDTH-1:0] blk_res_1,
  input  logic [DATA_OUT_WIDTH-1:0] blk_res_2,
  input  logic [DATA_OUT_WIDTH-1:0] blk_res_3,
  output logic [DATA_OUT_WIDTH-1:0] m_data,
  output logic [1:0]                m_lane,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [1:0]                dbg_state_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {FILL, PAD, ISSUE, DRAIN} state_t;
  typedef logic [DATA_IN_WIDTH-1:0] lane_t;

  state_t                 state_q, state_d;
  logic [1:0]             lane_cnt_q, lane_cnt_d;
  lane_t                  lane_q [3];
  lane_t                  lane_d [3];
  lane_t                  blk_q [3];
  lane_t                  blk_d [3];
  logic [FIR_LATENCY-1:0] tag_q, tag_d;
  logic                   pad_q, pad_d;
  logic [3:0]             drain_q, drain_d;
  logic                   busy_q, busy_d;
  logic [1:0]             sel_q, sel_d;
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_OUT_WIDTH-1:0] mem1 [FIFO_DEPTH];
  logic [DATA_OUT_WIDTH-1:0] mem2 [FIFO_DEPTH];
  logic [DATA_OUT_WIDTH-1:0] mem3 [FIFO_DEPTH];
  logic                   adv, adv_ok, push, pop, hs, fifo_full;

  // Output handshake: a beat transfers on any cycle with m_valid && m_ready;
  // the input side takes a sample on s_valid && s_ready.
  assign fifo_full   = (cnt_q == CW'(FIFO_DEPTH));
  assign m_valid     = (cnt_q != '0);
  assign hs          = m_valid && m_ready;
  assign pop         = hs && (sel_q == 2'd2);
  // Advancing is safe unless it would push into a full FIFO that is not popping.
  assign adv_ok      = !fifo_full || pop || !tag_q[FIR_LATENCY-1];
  assign s_ready     = (state_q == FILL) && !flush && !reset;
  assign blk_adv     = adv;
  assign flush_busy  = busy_q;
  assign blk_data_1  = blk_q[0];
  assign blk_data_2  = blk_q[1];
  assign blk_data_3  = blk_q[2];
  assign m_lane      = sel_q;
  assign dbg_state_o = state_q;

  always_comb begin
    m_data = '0;
    if (m_valid) begin
      case (sel_q)
        2'd0:    m_data = mem1[rd_q];
        2'd1:    m_data = mem2[rd_q];
        default: m_data = mem3[rd_q];
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    lane_d     = lane_q;
    blk_d      = blk_q;
    tag_d      = tag_q;
    pad_d      = pad_q;
    drain_d    = drain_q;
    busy_d     = busy_q;
    adv        = 1'b0;
    push       = 1'b0;
    case (state_q)
      FILL: begin
        if (flush) begin
          busy_d  = 1'b1;
          state_d = PAD;
        end else if (s_valid && s_ready) begin
          for (int i = 0; i < 3; i++) begin
            if (2'(i) == lane_cnt_q) lane_d[i] = s_data;
          end
          if (lane_cnt_q == 2'd2) begin
            blk_d[0]   = lane_q[0];
            blk_d[1]   = lane_q[1];
            blk_d[2]   = s_data;
            lane_cnt_d = 2'd0;
            state_d    = ISSUE;
          end else begin
            lane_cnt_d = lane_cnt_q + 2'd1;
          end
        end
      end
      PAD: begin
        for (int i = 0; i < 3; i++) begin
          if (2'(i) >= lane_cnt_q) begin
            lane_d[i] = '0;
            blk_d[i]  = '0;
          end else begin
            blk_d[i]  = lane_q[i];
          end
        end
        lane_cnt_d = 2'd0;
        if (lane_cnt_q == 2'd0) begin
          drain_d = 4'(FIR_LATENCY);
          state_d = DRAIN;
        end else begin
          pad_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (adv_ok) begin
          adv   = 1'b1;
          pad_d = 1'b0;
          if (pad_q || flush) begin
            busy_d  = 1'b1;
            drain_d = 4'(FIR_LATENCY);
            blk_d   = '{default: '0};
            state_d = DRAIN;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: begin
        if (drain_q == 4'd0) begin
          busy_d  = 1'b0;
          state_d = FILL;
        end else if (adv_ok) begin
          adv     = 1'b1;
          drain_d = drain_q - 4'd1;
        end
      end
    endcase
    // Tag bit marks blocks whose results must be captured; drain blocks carry 0.
    if (adv) begin
      tag_d    = tag_q << 1;
      tag_d[0] = (state_q == ISSUE);
      push     = tag_q[FIR_LATENCY-1];
    end
  end

  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    sel_d = sel_q;
    if (hs) sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL;
      lane_cnt_q <= 2'd0;
      lane_q     <= '{default: '0};
      blk_q      <= '{default: '0};
      tag_q      <= '0;
      pad_q      <= 1'b0;
      drain_q    <= 4'd0;
      busy_q     <= 1'b0;
      sel_q      <= 2'd0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      lane_q     <= lane_d;
      blk_q      <= blk_d;
      tag_q      <= tag_d;
      pad_q      <= pad_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      sel_q      <= sel_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem1[wr_q] <= blk_res_1;
      mem2[wr_q] <= blk_res_2;
      mem3[wr_q] <= blk_res_3;
    end
  end

endmodule

// File: tb/tb_fir_l3_stream_ctrl.sv
// Directed bench for fir_l3_stream_ctrl: instance A uses default parameters,
// instance B uses FIR_LATENCY=1 / FIFO_DEPTH=2; both drive mock delay-line cores.
module tb_fir_l3_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, s_valid_a, s_ready_a, flush_a, busy_a, adv_a, m_valid_a, m_ready_a;
  logic [15:0] s_data_a, bd1_a, bd2_a, bd3_a;
  logic [63:0] br1_a, br2_a, br3_a, m_data_a;
  logic [1:0]  m_lane_a, st_a;

  logic        rst_b, s_valid_b, s_ready_b, flush_b, busy_b, adv_b, m_valid_b, m_ready_b;
  logic [15:0] s_data_b, bd1_b, bd2_b, bd3_b;
  logic [63:0] br1_b, br2_b, br3_b, m_data_b;
  logic [1:0]  m_lane_b, st_b;

  fir_l3_stream_ctrl dut_a (
    .clk(clk), .reset(rst_a), .s_data(s_data_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .flush(flush_a), .flush_busy(busy_a), .blk_data_1(bd1_a), .blk_data_2(bd2_a),
    .blk_data_3(bd3_a), .blk_adv(adv_a), .blk_res_1(br1_a), .blk_res_2(br2_a),
    .blk_res_3(br3_a), .m_data(m_data_a), .m_lane(m_lane_a), .m_valid(m_valid_a),
    .m_ready(m_ready_a), .dbg_state_o(st_a)
  );

  fir_l3_stream_ctrl #(.FIR_LATENCY(1), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .reset(rst_b), .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .flush(flush_b), .flush_busy(busy_b), .blk_data_1(bd1_b), .blk_data_2(bd2_b),
    .blk_data_3(bd3_b), .blk_adv(adv_b), .blk_res_1(br1_b), .blk_res_2(br2_b),
    .blk_res_3(br3_b), .m_data(m_data_b), .m_lane(m_lane_b), .m_valid(m_valid_b),
    .m_ready(m_ready_b), .dbg_state_o(st_b)
  );

  // Mock cores: results are the issued lanes, sign-extended, FIR_LATENCY advances later.
  logic [47:0] ca0, ca1, cb0;
  always_ff @(posedge clk) begin
    if (rst_a) begin
      ca0 <= '0;
      ca1 <= '0;
    end else if (adv_a) begin
      ca0 <= {bd1_a, bd2_a, bd3_a};
      ca1 <= ca0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_b) cb0 <= '0;
    else if (adv_b) cb0 <= {bd1_b, bd2_b, bd3_b};
  end
  assign br1_a = {{48{ca1[47]}}, ca1[47:32]};
  assign br2_a = {{48{ca1[31]}}, ca1[31:16]};
  assign br3_a = {{48{ca1[15]}}, ca1[15:0]};
  assign br1_b = {{48{cb0[47]}}, cb0[47:32]};
  assign br2_b = {{48{cb0[31]}}, cb0[31:16]};
  assign br3_b = {{48{cb0[15]}}, cb0[15:0]};

  int total = 0;
  int bad = 0;
  logic [63:0] exp_a_q[$];
  logic [63:0] exp_b_q[$];
  int lane_a, lane_b, pend_a, pend_b, beats_a, beats_b;
  int advs_a, advs_b, dadv_a, dadv_b, accs_a;
  bit acc_a, acc_b, rand_rdy_a;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    acc_a = s_valid_a && s_ready_a;
    acc_b = s_valid_b && s_ready_b;
    if (m_valid_a && m_ready_a) begin
      check("a_beat_expected", exp_a_q.size() > 0, 1);
      if (exp_a_q.size() > 0) check("a_data", m_data_a, exp_a_q.pop_front());
      check("a_lane", m_lane_a, lane_a);
      lane_a = (lane_a + 1) % 3;
      beats_a++;
    end
    if (m_valid_b && m_ready_b) begin
      check("b_beat_expected", exp_b_q.size() > 0, 1);
      if (exp_b_q.size() > 0) check("b_data", m_data_b, exp_b_q.pop_front());
      check("b_lane", m_lane_b, lane_b);
      lane_b = (lane_b + 1) % 3;
      beats_b++;
    end
    if (adv_a) begin advs_a++; if (busy_a) dadv_a++; end
    if (adv_b) begin advs_b++; if (busy_b) dadv_b++; end
  endtask

  task automatic tick();
    if (rand_rdy_a) m_ready_a = ($urandom_range(0, 99) < 60);
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [15:0] v);
    int n = 0;
    s_valid_a = 1'b1;
    s_data_a  = v;
    do begin tick(); n++; end while (!acc_a && n < 300);
    s_valid_a = 1'b0;
    check("a_accept", acc_a, 1);
    if (acc_a) begin
      exp_a_q.push_back({{48{v[15]}}, v});
      pend_a = (pend_a + 1) % 3;
      accs_a++;
    end
  endtask

  task automatic send_b(input logic [15:0] v);
    int n = 0;
    s_valid_b = 1'b1;
    s_data_b  = v;
    do begin tick(); n++; end while (!acc_b && n < 300);
    s_valid_b = 1'b0;
    check("b_accept", acc_b, 1);
    if (acc_b) begin
      exp_b_q.push_back({{48{v[15]}}, v});
      pend_b = (pend_b + 1) % 3;
    end
  endtask

  task automatic do_flush_a();
    int n = 0;
    if (pend_a != 0) begin
      repeat (3 - pend_a) exp_a_q.push_back('0);
      pend_a = 0;
    end
    flush_a = 1'b1;
    do begin tick(); n++; end while (!busy_a && n < 500);
    flush_a = 1'b0;
    check("a_busy_rise", busy_a, 1);
    n = 0;
    while (busy_a && n < 500) begin tick(); n++; end
    check("a_busy_fall", busy_a, 0);
    n = 0;
    while (exp_a_q.size() != 0 && n < 3000) begin tick(); n++; end
    check("a_queue_empty", exp_a_q.size(), 0);
    repeat (6) tick();
  endtask

  task automatic do_flush_b();
    int n = 0;
    if (pend_b != 0) begin
      repeat (3 - pend_b) exp_b_q.push_back('0);
      pend_b = 0;
    end
    flush_b = 1'b1;
    do begin tick(); n++; end while (!busy_b && n < 500);
    flush_b = 1'b0;
    check("b_busy_rise", busy_b, 1);
    n = 0;
    while (busy_b && n < 500) begin tick(); n++; end
    check("b_busy_fall", busy_b, 0);
    n = 0;
    while (exp_b_q.size() != 0 && n < 3000) begin tick(); n++; end
    check("b_queue_empty", exp_b_q.size(), 0);
    repeat (6) tick();
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    s_valid_a = 1'b0; s_valid_b = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
    s_data_a = '0; s_data_b = '0; m_ready_a = 1'b1; m_ready_b = 1'b1;
    rand_rdy_a = 1'b0;
    lane_a = 0; lane_b = 0; pend_a = 0; pend_b = 0; beats_a = 0; beats_b = 0;
    advs_a = 0; advs_b = 0; dadv_a = 0; dadv_b = 0; accs_a = 0;

    // Reset values
    repeat (3) tick();
    check("rst_m_valid", m_valid_a, 0);
    check("rst_m_data", m_data_a, 0);
    check("rst_m_lane", m_lane_a, 0);
    check("rst_blk_adv", adv_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_blk_data", {bd1_a, bd2_a, bd3_a}, 0);
    check("rst_s_ready", s_ready_a, 0);
    check("rst_b_m_valid", m_valid_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    check("rst_rel_s_ready", s_ready_a, 1);
    check("rst_state", st_a, 0);

    // 1..12 then flush: 12 beats, two drain advances
    beats_a = 0; dadv_a = 0;
    for (int i = 1; i <= 12; i++) send_a(16'(i));
    do_flush_a();
    check("t1_beats", beats_a, 12);
    check("t1_drain_advs", dadv_a, 2);

    // 5, 6, flush: padded block adds a zero on lane 2
    beats_a = 0; dadv_a = 0;
    send_a(16'd5);
    send_a(16'd6);
    do_flush_a();
    check("t2_beats", beats_a, 3);
    check("t2_pad_and_drain_advs", dadv_a, 3);

    // Backpressure: 4 blocks in FIFO, 2 in core, 1 waiting in ISSUE -> 21 samples, 6 advances
    m_ready_a = 1'b0; advs_a = 0; beats_a = 0;
    for (int i = 0; i < 21; i++) send_a(16'(200 + i));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_s_ready_low", s_ready_a, 0);
    end
    check("t3_advs", advs_a, 6);
    check("t3_m_valid", m_valid_a, 1);
    check("t3_no_beats", beats_a, 0);
    rand_rdy_a = 1'b1;
    do_flush_a();
    rand_rdy_a = 1'b0;
    m_ready_a = 1'b1;
    check("t3_beats", beats_a, 21);

    // 300 samples with idle gaps: exactly one advance per 3 accepts
    advs_a = 0; dadv_a = 0; accs_a = 0; beats_a = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 30) tick();
      send_a(16'($urandom_range(0, 65535)));
    end
    repeat (3) tick();
    check("t4_accepts", accs_a, 300);
    check("t4_data_advs", advs_a - dadv_a, 100);
    do_flush_a();
    check("t4_beats", beats_a, 300);

    // Reset with two blocks in flight discards them
    for (int i = 0; i < 7; i++) send_a(16'(100 + i));
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    exp_a_q.delete();
    lane_a = 0; pend_a = 0; beats_a = 0;
    #1;
    check("t5_m_valid", m_valid_a, 0);
    check("t5_s_ready", s_ready_a, 1);
    check("t5_busy", busy_a, 0);
    check("t5_state", st_a, 0);
    for (int i = 7; i <= 12; i++) send_a(16'(i));
    do_flush_a();
    check("t5_beats", beats_a, 6);

    // Latency 1, depth 2, negative samples
    beats_b = 0; dadv_b = 0;
    send_b(16'hFFFF);
    send_b(16'h8000);
    send_b(16'h0003);
    do_flush_b();
    check("t6_drain_advs", dadv_b, 1);
    check("t6_beats", beats_b, 3);
    dadv_b = 0;
    send_b(16'hFFFF);
    do_flush_b();
    check("t6_pad_drain_advs", dadv_b, 2);
    check("t6_total_beats", beats_b, 6);
    check("t6_state", st_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
